axi_uart_console: RTL and testbench

// - AXI4 slave console for the MemPool testbench fabric, mapped at 0xC000_0000-0xC000_FFFF behind the testbench crossbar.
// - Decodes a minimal 16550-style register map: bytes written to THR are emitted as a character stream; LSR always reports "transmitter idle".
// - Independent read and write engines, one outstanding transaction each, INCR bursts supported; never stalls the core.

---
 rtl/axi_uart_console_pkg.sv | 87 ++++++++
 rtl/axi_uart_console_regfile.sv | 47 ++++
 rtl/axi_uart_console.sv | 206 ++++++++++++++++++++
 tb/tb_axi_uart_console.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_uart_console_pkg.sv
// Shared types and constants for the AXI4 UART console: channel payloads,
// response/burst encodings, register map and the per-beat address step.
package axi_uart_console_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned IdWidth   = 6;
    localparam int unsigned LaneWidth = $clog2(StrbWidth);
    localparam int unsigned OffWidth  = 5;
    localparam int unsigned LenWidth  = 8;

    typedef logic [1:0] resp_t;
    localparam resp_t RespOkay = 2'b00;

    typedef logic [1:0] burst_t;
    localparam burst_t BurstFixed = 2'b00;
    localparam burst_t BurstIncr  = 2'b01;
    localparam burst_t BurstWrap  = 2'b10;

    localparam logic [OffWidth-1:0] RegThr  = 5'h00;
    localparam logic [OffWidth-1:0] RegLsr  = 5'h14;
    localparam logic [7:0]          LsrIdle = 8'h60;

    typedef enum logic [1:0] {WrIdle, WrData, WrResp} wr_state_e;
    typedef enum logic       {RdIdle, RdData} rd_state_e;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [LenWidth-1:0]  len;
        logic [2:0]           size;
        burst_t               burst;
    } aw_chan_t;

    typedef aw_chan_t ar_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        resp_t              resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        resp_t                resp;
        logic                 last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;

    // Address of the following beat: FIXED holds, INCR and WRAP step by 1<<size.
    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] addr,
                                                       input logic [2:0]           size,
                                                       input burst_t               burst);
        if (burst == BurstFixed) begin
            return addr;
        end
        return addr + (AddrWidth'(1) << size);
    endfunction

endpackage

// File: rtl/axi_uart_console_regfile.sv
// Register decode for the console: THR write produces a registered character
// strobe, reads return LSR idle status or zero.
module axi_uart_regfile
    import axi_uart_console_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [OffWidth-1:0]  wr_off_i,
    input  logic [LaneWidth-1:0] wr_lane_i,
    input  logic [DataWidth-1:0] wr_data_i,
    input  logic [StrbWidth-1:0] wr_strb_i,
    input  logic [OffWidth-1:0]  rd_off_i,
    output logic [7:0]           rd_byte_c_o,
    output logic [7:0]           char_o,
    output logic                 char_valid_o
);

    logic       char_we_c;
    logic [7:0] char_byte_c;
    logic [7:0] char_q;
    logic       char_valid_q;

    // Decode a write beat into a character strobe and select the read byte.
    always_comb begin
        char_we_c   = wr_en_i && (wr_off_i == RegThr) && wr_strb_i[wr_lane_i];
        char_byte_c = wr_data_i[{wr_lane_i, 3'b000} +: 8];
        rd_byte_c_o = (rd_off_i == RegLsr) ? LsrIdle : 8'h00;
    end

    // Character output stage: one-cycle strobe, byte held until next write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            char_q       <= 8'h00;
            char_valid_q <= 1'b0;
        end else begin
            char_valid_q <= char_we_c;
            if (char_we_c) begin
                char_q <= char_byte_c;
            end
        end
    end

    assign char_o       = char_q;
    assign char_valid_o = char_valid_q;

endmodule

// File: rtl/axi_uart_console.sv
// AXI4 slave console: independent single-outstanding write and read engines
// in front of a minimal 16550-style register map.
module axi_uart_console
    import axi_uart_console_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      testmode_i,
    input  axi_req_t  axi_req_i,
    output axi_resp_t axi_resp_o,
    output logic [7:0] char_o,
    output logic      char_valid_o
);

    wr_state_e             wr_state_q, wr_state_d;
    logic [IdWidth-1:0]    wr_id_q, wr_id_d;
    logic [AddrWidth-1:0]  wr_addr_q, wr_addr_d;
    logic [LenWidth-1:0]   wr_len_q, wr_len_d;
    logic [2:0]            wr_size_q, wr_size_d;
    burst_t                wr_burst_q, wr_burst_d;
    logic [LenWidth-1:0]   wr_cnt_q, wr_cnt_d;
    logic                  aw_ready_q, w_ready_q, b_valid_q;

    rd_state_e             rd_state_q, rd_state_d;
    logic [IdWidth-1:0]    rd_id_q, rd_id_d;
    logic [AddrWidth-1:0]  rd_addr_q, rd_addr_d;
    logic [LenWidth-1:0]   rd_len_q, rd_len_d;
    logic [2:0]            rd_size_q, rd_size_d;
    burst_t                rd_burst_q, rd_burst_d;
    logic [LenWidth-1:0]   rd_cnt_q, rd_cnt_d;
    logic                  ar_ready_q, r_valid_q, r_last_q;
    logic [DataWidth-1:0]  r_data_q;

    logic                  aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic [7:0]            rd_byte_c;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    assign aw_fire = axi_req_i.aw_valid && aw_ready_q;
    assign w_fire  = axi_req_i.w_valid  && w_ready_q;
    assign b_fire  = b_valid_q && axi_req_i.b_ready;
    assign ar_fire = axi_req_i.ar_valid && ar_ready_q;
    assign r_fire  = r_valid_q && axi_req_i.r_ready;

    axi_uart_regfile u_regfile (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_en_i      (w_fire),
        .wr_off_i     (wr_addr_q[OffWidth-1:0]),
        .wr_lane_i    (wr_addr_q[LaneWidth-1:0]),
        .wr_data_i    (axi_req_i.w.data),
        .wr_strb_i    (axi_req_i.w.strb),
        .rd_off_i     (rd_addr_d[OffWidth-1:0]),
        .rd_byte_c_o  (rd_byte_c),
        .char_o       (char_o),
        .char_valid_o (char_valid_o)
    );

    // Write engine next state: latch AW, consume beats, hold B until accepted.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_id_d    = wr_id_q;
        wr_addr_d  = wr_addr_q;
        wr_len_d   = wr_len_q;
        wr_size_d  = wr_size_q;
        wr_burst_d = wr_burst_q;
        wr_cnt_d   = wr_cnt_q;
        case (wr_state_q)
            WrIdle: begin
                if (aw_fire) begin
                    wr_id_d    = axi_req_i.aw.id;
                    wr_addr_d  = axi_req_i.aw.addr;
                    wr_len_d   = axi_req_i.aw.len;
                    wr_size_d  = axi_req_i.aw.size;
                    wr_burst_d = axi_req_i.aw.burst;
                    wr_cnt_d   = '0;
                    wr_state_d = WrData;
                end
            end
            WrData: begin
                if (w_fire) begin
                    wr_addr_d = next_addr(wr_addr_q, wr_size_q, wr_burst_q);
                    wr_cnt_d  = wr_cnt_q + LenWidth'(1);
                    if (axi_req_i.w.last || (wr_cnt_q == wr_len_q)) begin
                        wr_state_d = WrResp;
                    end
                end
            end
            WrResp: begin
                if (b_fire) begin
                    wr_state_d = WrIdle;
                end
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    // Write engine registers; handshake outputs follow the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= WrIdle;
            wr_id_q    <= '0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wr_size_q  <= '0;
            wr_burst_q <= BurstIncr;
            wr_cnt_q   <= '0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_id_q    <= wr_id_d;
            wr_addr_q  <= wr_addr_d;
            wr_len_q   <= wr_len_d;
            wr_size_q  <= wr_size_d;
            wr_burst_q <= wr_burst_d;
            wr_cnt_q   <= wr_cnt_d;
            aw_ready_q <= (wr_state_d == WrIdle);
            w_ready_q  <= (wr_state_d == WrData);
            b_valid_q  <= (wr_state_d == WrResp);
        end
    end

    // Read engine next state: latch AR, then stream len+1 beats.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_id_d    = rd_id_q;
        rd_addr_d  = rd_addr_q;
        rd_len_d   = rd_len_q;
        rd_size_d  = rd_size_q;
        rd_burst_d = rd_burst_q;
        rd_cnt_d   = rd_cnt_q;
        case (rd_state_q)
            RdIdle: begin
                if (ar_fire) begin
                    rd_id_d    = axi_req_i.ar.id;
                    rd_addr_d  = axi_req_i.ar.addr;
                    rd_len_d   = axi_req_i.ar.len;
                    rd_size_d  = axi_req_i.ar.size;
                    rd_burst_d = axi_req_i.ar.burst;
                    rd_cnt_d   = '0;
                    rd_state_d = RdData;
                end
            end
            RdData: begin
                if (r_fire) begin
                    if (rd_cnt_q == rd_len_q) begin
                        rd_state_d = RdIdle;
                    end else begin
                        rd_cnt_d  = rd_cnt_q + LenWidth'(1);
                        rd_addr_d = next_addr(rd_addr_q, rd_size_q, rd_burst_q);
                    end
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    // Read engine registers; R payload is precomputed for the upcoming beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_state_q <= RdIdle;
            rd_id_q    <= '0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_size_q  <= '0;
            rd_burst_q <= BurstIncr;
            rd_cnt_q   <= '0;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_data_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_id_q    <= rd_id_d;
            rd_addr_q  <= rd_addr_d;
            rd_len_q   <= rd_len_d;
            rd_size_q  <= rd_size_d;
            rd_burst_q <= rd_burst_d;
            rd_cnt_q   <= rd_cnt_d;
            ar_ready_q <= (rd_state_d == RdIdle);
            r_valid_q  <= (rd_state_d == RdData);
            r_last_q   <= (rd_cnt_d == rd_len_d);
            r_data_q   <= DataWidth'(rd_byte_c) << {rd_addr_d[LaneWidth-1:0], 3'b000};
        end
    end

    // Pack the response channels.
    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready_q;
        axi_resp_o.w_ready  = w_ready_q;
        axi_resp_o.b_valid  = b_valid_q;
        axi_resp_o.b.id     = wr_id_q;
        axi_resp_o.b.resp   = RespOkay;
        axi_resp_o.ar_ready = ar_ready_q;
        axi_resp_o.r_valid  = r_valid_q;
        axi_resp_o.r.id     = rd_id_q;
        axi_resp_o.r.data   = r_data_q;
        axi_resp_o.r.resp   = RespOkay;
        axi_resp_o.r.last   = r_last_q;
    end

endmodule

// File: tb/tb_axi_uart_console.sv
// Scoreboard bench for axi_uart_console: directed AXI transactions push
// expected B/R/char responses; one monitor pops and compares on each output.
module tb_axi_uart_console;
    import axi_uart_console_pkg::*;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic                 last;
    } r_exp_t;

    logic       clk;
    logic       rst_i;
    logic       testmode_i;
    axi_req_t   req;
    axi_resp_t  resp;
    logic [7:0] char_o;
    logic       char_valid_o;

    int unsigned errors;
    int unsigned checks;

    logic [7:0]         exp_char[$];
    logic [IdWidth-1:0] exp_b[$];
    r_exp_t             exp_r[$];

    axi_uart_console dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .testmode_i   (testmode_i),
        .axi_req_i    (req),
        .axi_resp_o   (resp),
        .char_o       (char_o),
        .char_valid_o (char_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            0:       return resp.aw_ready;
            1:       return resp.w_ready;
            default: return resp.ar_ready;
        endcase
    endfunction

    // Wait (bounded) for the selected ready, complete the handshake on the next edge.
    task automatic handshake(input int sel, input string name);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = rdy(sel);
        end
        check({name, "_ready_seen"}, 64'(ok), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [IdWidth-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input burst_t burst,
                            input int nbeats, input logic [3:0][31:0] data,
                            input logic [3:0][3:0] strb);
        req.aw.id    = id;
        req.aw.addr  = addr;
        req.aw.len   = len;
        req.aw.size  = size;
        req.aw.burst = burst;
        req.aw_valid = 1'b1;
        handshake(0, "aw");
        req.aw_valid = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            req.w.data  = data[k];
            req.w.strb  = strb[k];
            req.w.last  = (k == nbeats - 1);
            req.w_valid = 1'b1;
            handshake(1, "w");
        end
        req.w_valid = 1'b0;
    endtask

    task automatic do_read(input logic [IdWidth-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size);
        req.ar.id    = id;
        req.ar.addr  = addr;
        req.ar.len   = len;
        req.ar.size  = size;
        req.ar.burst = BurstIncr;
        req.ar_valid = 1'b1;
        handshake(2, "ar");
        req.ar_valid = 1'b0;
    endtask

    // Bounded wait for all expected responses, then a few idle cycles.
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_b.size() + exp_r.size() + exp_char.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_pending"}, 64'(exp_b.size() + exp_r.size() + exp_char.size()), 64'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every B/R handshake and char strobe.
    initial begin : monitor
        logic               b_stall;
        b_chan_t            b_prev;
        logic [IdWidth-1:0] eid;
        r_exp_t             re;
        logic [7:0]         ce;
        b_stall = 1'b0;
        b_prev  = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                b_stall = 1'b0;
            end else begin
                if (b_stall) begin
                    check("b_held_valid", 64'(resp.b_valid), 64'(1));
                    check("b_held_payload", 64'(resp.b), 64'(b_prev));
                end
                if (resp.b_valid && req.b_ready) begin
                    checks++;
                    if (exp_b.size() == 0) begin
                        errors++;
                        $display("FAIL b_unexpected: got B id 0x%0h, required none", resp.b.id);
                    end else begin
                        eid = exp_b.pop_front();
                        check("b_id", 64'(resp.b.id), 64'(eid));
                        check("b_resp", 64'(resp.b.resp), 64'(RespOkay));
                    end
                end
                b_stall = resp.b_valid && !req.b_ready;
                b_prev  = resp.b;
                if (resp.r_valid && req.r_ready) begin
                    checks++;
                    if (exp_r.size() == 0) begin
                        errors++;
                        $display("FAIL r_unexpected: got R data 0x%0h, required none", resp.r.data);
                    end else begin
                        re = exp_r.pop_front();
                        check("r_id", 64'(resp.r.id), 64'(re.id));
                        check("r_data", 64'(resp.r.data), 64'(re.data));
                        check("r_last", 64'(resp.r.last), 64'(re.last));
                        check("r_resp", 64'(resp.r.resp), 64'(RespOkay));
                    end
                end
                if (char_valid_o) begin
                    checks++;
                    if (exp_char.size() == 0) begin
                        errors++;
                        $display("FAIL char_unexpected: got char 0x%0h, required none", char_o);
                    end else begin
                        ce = exp_char.pop_front();
                        check("char_o", 64'(char_o), 64'(ce));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [3:0][31:0] d;
        logic [3:0][3:0]  s;
        errors     = 0;
        checks     = 0;
        testmode_i = 1'b0;
        rst_i      = 1'b1;
        req        = '0;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_aw_ready", 64'(resp.aw_ready), 64'(0));
        check("rst_ar_ready", 64'(resp.ar_ready), 64'(0));
        check("rst_w_ready", 64'(resp.w_ready), 64'(0));
        check("rst_b_valid", 64'(resp.b_valid), 64'(0));
        check("rst_r_valid", 64'(resp.r_valid), 64'(0));
        check("rst_char_valid", 64'(char_valid_o), 64'(0));
        check("rst_char_o", 64'(char_o), 64'(0));
        rst_i = 1'b0;

        // Single write of 'A' to THR.
        d = '0; s = '0;
        d[0] = 32'h0000_0041; s[0] = 4'hF;
        exp_char.push_back(8'h41); exp_b.push_back(6'h0D);
        do_write(6'h0D, 32'hC000_0000, 8'd0, 3'd2, BurstIncr, 1, d, s);
        drain("write_thr");

        // LSR read with first-beat latency check; then a plain offset.
        exp_r.push_back('{id: 6'h03, data: 32'h0000_0060, last: 1'b1});
        do_read(6'h03, 32'hC000_0014, 8'd0, 3'd2);
        @(negedge clk);
        check("r_latency", 64'(resp.r_valid), 64'(1));
        drain("read_lsr");
        exp_r.push_back('{id: 6'h04, data: 32'h0000_0000, last: 1'b1});
        do_read(6'h04, 32'hC000_0008, 8'd0, 3'd2);
        drain("read_08");
        exp_r.push_back('{id: 6'h06, data: 32'h0000_0060, last: 1'b1});
        do_read(6'h06, 32'hC000_0034, 8'd0, 3'd2);
        drain("read_alias");

        // Byte-sized INCR read burst crossing the LSR.
        exp_r.push_back('{id: 6'h2A, data: 32'h0000_0000, last: 1'b0});
        exp_r.push_back('{id: 6'h2A, data: 32'h0000_0060, last: 1'b0});
        exp_r.push_back('{id: 6'h2A, data: 32'h0000_0000, last: 1'b1});
        do_read(6'h2A, 32'hC000_0013, 8'd2, 3'd0);
        drain("read_burst");

        // "Hi!\n" as a byte INCR burst: only offset 0 strobes.
        d[0] = 32'h0000_0048; s[0] = 4'h1;
        d[1] = 32'h0000_6900; s[1] = 4'h2;
        d[2] = 32'h0021_0000; s[2] = 4'h4;
        d[3] = 32'h0A00_0000; s[3] = 4'h8;
        exp_char.push_back(8'h48); exp_b.push_back(6'h11);
        do_write(6'h11, 32'hC000_0000, 8'd3, 3'd0, BurstIncr, 4, d, s);
        drain("burst_hi");

        // Aliased THR, early w.last ends a len=3 burst after two beats.
        d[0] = 32'h0000_0051; s[0] = 4'hF;
        d[1] = 32'h0000_0052; s[1] = 4'hF;
        exp_char.push_back(8'h51); exp_b.push_back(6'h12);
        do_write(6'h12, 32'hC000_0020, 8'd3, 3'd2, BurstIncr, 2, d, s);
        drain("early_last");

        // FIXED burst keeps hitting THR.
        d[0] = 32'h0000_0061; d[1] = 32'h0000_0062;
        exp_char.push_back(8'h61); exp_char.push_back(8'h62); exp_b.push_back(6'h13);
        do_write(6'h13, 32'hC000_0000, 8'd1, 3'd2, BurstFixed, 2, d, s);
        drain("fixed_burst");

        // Zero strobe: B only, no character.
        d[0] = 32'h0000_0077; s[0] = 4'h0;
        exp_b.push_back(6'h05);
        do_write(6'h05, 32'hC000_0000, 8'd0, 3'd2, BurstIncr, 1, d, s);
        drain("strb_zero");

        // Concurrent AW+AR with B stalled for 5 cycles.
        req.b_ready = 1'b0;
        exp_b.push_back(6'h21); exp_char.push_back(8'h41);
        exp_r.push_back('{id: 6'h07, data: 32'h0000_0060, last: 1'b0});
        exp_r.push_back('{id: 6'h07, data: 32'h0000_0000, last: 1'b1});
        req.aw.id = 6'h21; req.aw.addr = 32'hC000_0000; req.aw.len = 8'd0;
        req.aw.size = 3'd2; req.aw.burst = BurstIncr;
        req.ar.id = 6'h07; req.ar.addr = 32'hC000_0014; req.ar.len = 8'd1;
        req.ar.size = 3'd2; req.ar.burst = BurstIncr;
        req.aw_valid = 1'b1; req.ar_valid = 1'b1;
        @(negedge clk);
        check("aw_ar_same_cycle", 64'({resp.aw_ready, resp.ar_ready}), 64'(2'b11));
        @(posedge clk);
        #1;
        req.aw_valid = 1'b0; req.ar_valid = 1'b0;
        req.w.data = 32'h0000_0041; req.w.strb = 4'hF; req.w.last = 1'b1; req.w_valid = 1'b1;
        handshake(1, "w_conc");
        req.w_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("b_stalled_valid", 64'(resp.b_valid), 64'(1));
        check("r_done_under_b_stall", 64'(exp_r.size()), 64'(0));
        @(posedge clk);
        #1;
        req.b_ready = 1'b1;
        drain("concurrent");

        // Reset during the write data phase with a beat offered.
        req.aw.id = 6'h09; req.aw.addr = 32'hC000_0000; req.aw.len = 8'd0;
        req.aw.size = 3'd2; req.aw.burst = BurstIncr; req.aw_valid = 1'b1;
        handshake(0, "aw_rst");
        req.aw_valid = 1'b0;
        @(negedge clk);
        check("w_ready_in_data", 64'(resp.w_ready), 64'(1));
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        req.w.data = 32'h0000_0058; req.w.strb = 4'hF; req.w.last = 1'b1; req.w_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_aw_ready", 64'(resp.aw_ready), 64'(0));
        check("midrst_w_ready", 64'(resp.w_ready), 64'(0));
        check("midrst_b_valid", 64'(resp.b_valid), 64'(0));
        check("midrst_char_valid", 64'(char_valid_o), 64'(0));
        check("midrst_char_o", 64'(char_o), 64'(0));
        rst_i = 1'b0;
        req.w_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        d[0] = 32'h0000_005A; s[0] = 4'hF;
        exp_char.push_back(8'h5A); exp_b.push_back(6'h0A);
        do_write(6'h0A, 32'hC000_0000, 8'd0, 3'd2, BurstIncr, 1, d, s);
        drain("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
